// File: rtl/data_memory_responder.sv
// Multi-cycle data memory for the load/store path, with valid/ready request and response channels.
// Optional address checking (misaligned / out of range) is enabled by defining DMEM_ERR_CHECK_EN.
module data_memory_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // req_* are sampled only in IDLE; resp_rdata/resp_err hold until resp_valid && resp_ready.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic                    write_q;
  logic [ADDR_WIDTH-1:0]   waddr_q;
  logic [31:0]             wdata_q;
  logic [3:0]              be_q;
  logic                    err_q;
  logic                    resp_err_q;

  logic [31:0]             mem [2**ADDR_WIDTH];

  logic                    err_now;
  logic                    acc_write;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [31:0]             acc_wdata;
  logic [3:0]              acc_be;
  logic                    acc_err;
  logic                    commit;

  assign fsm_state = state_q;

`ifdef DMEM_ERR_CHECK_EN
  assign err_now  = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_WIDTH+2] != '0);
  assign resp_err = resp_err_q;
`else
  logic unused_bits;
  assign err_now     = 1'b0;
  assign resp_err    = 1'b0;
  assign unused_bits = ^{req_addr[1:0], req_addr[31:ADDR_WIDTH+2], resp_err_q};
`endif

  // With LATENCY=1 the access happens on the acceptance edge, so it must use the live request.
  always_comb begin
    acc_write = write_q;
    acc_addr  = waddr_q;
    acc_wdata = wdata_q;
    acc_be    = be_q;
    acc_err   = err_q;
    commit    = 1'b0;
    if (state_q == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr[ADDR_WIDTH+1:2];
      acc_wdata = req_wdata;
      acc_be    = req_be;
      acc_err   = err_now;
      commit    = req_valid && (LATENCY == 1);
    end else if (state_q == WAIT) begin
      commit    = (cnt_q == 4'd1);
    end
  end

  // Storage has no reset; an uncommitted store is dropped because reset forces IDLE.
  always_ff @(posedge clk) begin
    if (commit && acc_write && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_addr][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err_q <= 1'b0;
      write_q    <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= 32'd0;
      be_q       <= 4'd0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q   <= req_write;
            waddr_q   <= req_addr[ADDR_WIDTH+1:2];
            wdata_q   <= req_wdata;
            be_q      <= req_be;
            err_q     <= err_now;
            req_ready <= 1'b0;
            if (commit) begin
              state_q    <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= (acc_write || acc_err) ? 32'd0 : mem[acc_addr];
              resp_err_q <= acc_err;
            end else begin
              state_q <= WAIT;
              cnt_q   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (commit) begin
            state_q    <= RESP;
            cnt_q      <= 4'd0;
            resp_valid <= 1'b1;
            resp_rdata <= (acc_write || acc_err) ? 32'd0 : mem[acc_addr];
            resp_err_q <= acc_err;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q    <= IDLE;
            resp_valid <= 1'b0;
            resp_err_q <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed and lightly randomised bench for data_memory_responder (LATENCY=2, ADDR_WIDTH=8).
// Expected responses are queued as requests are issued and compared when resp_valid appears.
module tb_data_memory_responder;
  localparam int AW  = 8;
  localparam int LAT = 2;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [1:0]  fsm_state;

  int vectors = 0;
  int miscompares = 0;
  logic [32:0] exp_q[$];

  data_memory_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one request from a negedge and returns #1 after the acceptance edge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    req_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (req_ready) break;
      @(negedge clk);
    end
    check("accept_ready", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Waits for the response, compares it with the queue head, applies backpressure, then handshakes.
  task automatic collect(input string tag, input int hold);
    logic [32:0] e;
    int edges = 1;
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      edges++;
    end
    check({tag, "_valid"}, 32'(seen), 1);
    check({tag, "_latency"}, edges, LAT);
    check({tag, "_queue_nonempty"}, 32'(exp_q.size() != 0), 1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'd0;
    check({tag, "_rdata"}, resp_rdata, e[31:0]);
    check({tag, "_err"}, 32'(resp_err), 32'(e[32]));
    check({tag, "_req_ready_low"}, 32'(req_ready), 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(resp_valid), 1);
      check({tag, "_hold_rdata"}, resp_rdata, e[31:0]);
      check({tag, "_hold_ready"}, 32'(req_ready), 0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    check({tag, "_done_valid"}, 32'(resp_valid), 0);
    check({tag, "_done_err"}, 32'(resp_err), 0);
    check({tag, "_done_ready"}, 32'(req_ready), 1);
  endtask

  task automatic txn(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic err, input logic [31:0] rdata);
    issue(w, a, d, be);
    exp_q.push_back({err, rdata});
    collect(tag, 0);
  endtask

  initial begin
    logic [31:0] d1, d2, merged;
    logic [3:0]  be;
    logic [31:0] a;

    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_low_resp_valid", 32'(resp_valid), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_req_ready", 32'(req_ready), 1);
    check("idle_resp_valid", 32'(resp_valid), 0);
    check("idle_resp_rdata", resp_rdata, 0);
    check("idle_resp_err", 32'(resp_err), 0);
    check("idle_state", 32'(fsm_state), 32'(S_IDLE));

    txn("sw10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'd0);
    txn("lw10", 1'b0, 32'h10, 32'd0, 4'h0, 1'b0, 32'hDEADBEEF);
    txn("sw10_lane0", 1'b1, 32'h10, 32'h00000055, 4'b0001, 1'b0, 32'd0);
    txn("lw10_partial", 1'b0, 32'h10, 32'd0, 4'h0, 1'b0, 32'hDEADBE55);
    txn("sw10_be0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'd0);
    txn("lw10_be0", 1'b0, 32'h10, 32'd0, 4'h0, 1'b0, 32'hDEADBE55);

    // Backpressure, with a second request waiting that must not enter on the handshake edge.
    issue(1'b0, 32'h10, 32'd0, 4'h0);
    exp_q.push_back({1'b0, 32'hDEADBE55});
    req_write = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
    collect("bp", 5);
    check("bp_no_accept_on_handshake", 32'(fsm_state), 32'(S_IDLE));
    exp_q.push_back({1'b0, 32'hDEADBE55});
    @(posedge clk);
    #1 req_valid = 1'b0;
    collect("bp_second", 0);

    // Reset during WAIT drops the store.
    txn("sw20_init", 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0, 32'd0);
    issue(1'b1, 32'h20, 32'h12345678, 4'hF);
    check("mid_in_wait", 32'(fsm_state), 32'(S_WAIT));
    reset = 1'b0;
    #1;
    check("mid_rst_state", 32'(fsm_state), 32'(S_IDLE));
    check("mid_rst_valid", 32'(resp_valid), 0);
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_valid_hold", 32'(resp_valid), 0);
    end
    reset = 1'b1;
    txn("lw20_after_rst", 1'b0, 32'h20, 32'd0, 4'h0, 1'b0, 32'hCAFEF00D);

    // Random byte-lane merges on words 32..39.
    for (int k = 0; k < 4; k++) begin
      a  = 32'($urandom_range(32, 39)) << 2;
      d1 = $urandom;
      d2 = $urandom;
      be = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) merged[8*i +: 8] = be[i] ? d2[8*i +: 8] : d1[8*i +: 8];
      txn("rnd_sw_full", 1'b1, a, d1, 4'hF, 1'b0, 32'd0);
      txn("rnd_sw_part", 1'b1, a, d2, be, 1'b0, 32'd0);
      txn("rnd_lw", 1'b0, a, 32'd0, 4'h0, 1'b0, merged);
    end

    txn("sw0_init", 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 1'b0, 32'd0);
`ifdef DMEM_ERR_CHECK_EN
    txn("err_lw_misaligned", 1'b0, 32'h13, 32'd0, 4'h0, 1'b1, 32'd0);
    txn("err_sw_range", 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 1'b1, 32'd0);
    txn("err_sw_misaligned", 1'b1, 32'h2, 32'h11111111, 4'hF, 1'b1, 32'd0);
    txn("lw0_unchanged", 1'b0, 32'h0, 32'd0, 4'h0, 1'b0, 32'h0BADF00D);
`else
    txn("alias_lw", 1'b0, 32'h413, 32'd0, 4'h0, 1'b0, 32'hDEADBE55);
    txn("alias_sw", 1'b1, 32'h402, 32'h11223344, 4'hF, 1'b0, 32'd0);
    txn("lw0_aliased", 1'b0, 32'h0, 32'd0, 4'h0, 1'b0, 32'h11223344);
`endif

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
